// File: rtl/rr_arb_pkg.sv
// Shared constants and width helper for the
// round-robin arbiter slice.
package rr_arb_pkg;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority pick: first set req bit
// starting at ptr, wrapping modulo N.
module rr_prio_pick
  import rr_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] win,
  output logic         any
);

  logic [W-1:0] w_idx;

  // scan far-to-near so the nearest hit wins
  always_comb begin
    win   = '0;
    w_idx = '0;
    any   = |req;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = W'((int'(ptr) + i) % N);
      if (req[w_idx]) win = w_idx;
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter with bounded lock hold,
// registered one-hot grant and index.
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                en,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        lock,
  output logic [N-1:0]        gnt,
  output logic [clog2(N)-1:0] gnt_id,
  output logic                gnt_valid
);

  localparam int W  = clog2(N);
  localparam int HW = clog2(MAX_HOLD + 1);

  logic [N-1:0]  r_gnt;
  logic [W-1:0]  r_id;
  logic          r_valid;
  logic [W-1:0]  r_ptr;
  logic [HW-1:0] r_hold;

  logic [W-1:0]  w_win;
  logic          w_any;
  logic          w_keep;
  logic [W-1:0]  w_ptr_nxt;
  logic [N-1:0]  w_onehot;

  rr_prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .win (w_win),
    .any (w_any)
  );

  // holder keeps the grant only while under the hold cap
  assign w_keep = r_valid
                & req[r_id]
                & lock[r_id]
                & (r_hold < HW'(MAX_HOLD));

  assign w_ptr_nxt = (w_win == W'(N - 1))
                   ? '0
                   : w_win + W'(1);

  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_gnt   <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else if (!en) begin
      r_gnt   <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else if (w_keep) begin
      r_hold  <= r_hold + HW'(1);
    end else if (w_any) begin
      r_gnt   <= w_onehot;
      r_id    <= w_win;
      r_valid <= 1'b1;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= HW'(1);
    end else begin
      r_gnt   <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_id;
  assign gnt_valid = r_valid;

endmodule
